// File: rtl/pipeline_muldiv_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface pipeline_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [2:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iFlush;
  logic             oBusy;
  logic [WIDTH-1:0] oHi;
  logic [WIDTH-1:0] oLo;
  logic             oDone;
  logic             oDivByZero;

  modport master (
    output iStart, iOp, iA, iB, iFlush,
    input  oBusy, oHi, oLo, oDone, oDivByZero
  );

  modport slave (
    input  iStart, iOp, iA, iB, iFlush,
    output oBusy, oHi, oLo, oDone, oDivByZero
  );
endinterface

// File: rtl/pipeline_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, run on magnitudes
// and sign-corrected in a final FIX cycle before committing.
module pipeline_muldiv #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input logic              clk,
  input logic              reset,
  pipeline_muldiv_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 signA_q, signA_d;
  logic                 signB_q, signB_d;
  logic                 isDiv_q, isDiv_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                    isSigned;
  logic [WIDTH-1:0]        absA, absB;
  logic [WIDTH+MUL_STEP-1:0] mulPart, mulSum;
  logic [WIDTH:0]          divTrial;
  logic [WIDTH-1:0]        divDiff;
  logic                    divGe;
  logic [2*WIDTH-1:0]      prodFix;
  logic [WIDTH-1:0]        quotFix, remFix;

  // MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  always_comb begin : datapath
    isSigned = ~bus.iOp[0];
    absA     = (isSigned && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    absB     = (isSigned && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
    mulPart  = {{MUL_STEP{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[MUL_STEP-1:0]};
    mulSum   = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mulPart;
    divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divGe    = (divTrial >= {1'b0, opnd_q});
    divDiff  = divTrial[WIDTH-1:0] - opnd_q;
    prodFix  = (signA_q ^ signB_q) ? -acc_q : acc_q;
    quotFix  = (signA_q ^ signB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix   = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin : nextState
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    signA_d = signA_q;
    signB_d = signB_q;
    isDiv_d = isDiv_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          if (!bus.iOp[2]) begin
            if (bus.iOp[1] && (bus.iB == '0)) begin
              dbz_d = 1'b1;
            end else begin
              signA_d = isSigned & bus.iA[WIDTH-1];
              signB_d = isSigned & bus.iB[WIDTH-1];
              isDiv_d = bus.iOp[1];
              opnd_d  = bus.iOp[1] ? absB : absA;
              acc_d   = {{WIDTH{1'b0}}, (bus.iOp[1] ? absA : absB)};
              cnt_d   = '0;
              state_d = bus.iOp[1] ? DIV : MUL;
            end
          end else if (!bus.iOp[1]) begin
            if (bus.iOp[0]) lo_d = bus.iA;
            else            hi_d = bus.iA;
          end
        end
      end
      // Low half holds the unretired multiplier bits; product bits shift in from the top.
      MUL: begin
        acc_d = {mulSum, acc_q[WIDTH-1:MUL_STEP]};
        if (cnt_q == MUL_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        acc_d = {(divGe ? divDiff : divTrial[WIDTH-1:0]), acc_q[WIDTH-2:0], divGe};
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quotFix;
        end else begin
          {hi_d, lo_d} = prodFix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort drops any pending commit or new command, leaving HI/LO untouched.
    if (bus.iFlush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = '0;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : stateReg
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      isDiv_q <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      signA_q <= signA_d;
      signB_q <= signB_d;
      isDiv_q <= isDiv_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.oBusy      = (state_q != IDLE);
  assign bus.oHi        = hi_q;
  assign bus.oLo        = lo_q;
  assign bus.oDone      = done_q;
  assign bus.oDivByZero = dbz_q;
endmodule

// File: tb/tb_pipeline_muldiv.sv
// Self-checking bench for pipeline_muldiv: directed cases plus randomized ops
// against a 64-bit arithmetic model, on MUL_STEP=1 and MUL_STEP=4 instances.
module tb_pipeline_muldiv;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int testsRun    = 0;
  int testsFailed = 0;

  pipeline_muldiv_if #(.WIDTH(W)) bus  ();
  pipeline_muldiv_if #(.WIDTH(W)) bus4 ();

  pipeline_muldiv #(.WIDTH(W), .MUL_STEP(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  pipeline_muldiv #(.WIDTH(W), .MUL_STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  function automatic logic obsBusy(input bit sel);
    return sel ? bus4.oBusy : bus.oBusy;
  endfunction
  function automatic logic obsDone(input bit sel);
    return sel ? bus4.oDone : bus.oDone;
  endfunction
  function automatic logic obsDbz(input bit sel);
    return sel ? bus4.oDivByZero : bus.oDivByZero;
  endfunction
  function automatic logic [W-1:0] obsHi(input bit sel);
    return sel ? bus4.oHi : bus.oHi;
  endfunction
  function automatic logic [W-1:0] obsLo(input bit sel);
    return sel ? bus4.oLo : bus.oLo;
  endfunction

  // Architectural result of one command using plain 64-bit arithmetic.
  function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, b,
                                   input int mulStep, inout logic [W-1:0] hi, lo,
                                   output int lat, output int dbz);
    longint sp, sq, sr;
    logic [2*W-1:0] up;
    lat = 0;
    dbz = 0;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; lat = W / mulStep + 1; end
      3'd1: begin up = 64'(a) * 64'(b); {hi, lo} = up; lat = W / mulStep + 1; end
      3'd2: if (b == 0) dbz = 1;
            else begin
              sq = longint'($signed(a)) / longint'($signed(b));
              sr = longint'($signed(a)) % longint'($signed(b));
              lo = W'(sq); hi = W'(sr); lat = W + 1;
            end
      3'd3: if (b == 0) dbz = 1;
            else begin lo = a / b; hi = a % b; lat = W + 1; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  task automatic setCmd(input bit sel, input logic start, input logic [2:0] op,
                        input logic [W-1:0] a, b);
    if (sel) begin
      bus4.iStart = start; bus4.iOp = op; bus4.iA = a; bus4.iB = b;
    end else begin
      bus.iStart = start; bus.iOp = op; bus.iA = a; bus.iB = b;
    end
  endtask

  task automatic applyReset();
    reset = 1'b0;
    bus.iFlush = 1'b0;
    bus4.iFlush = 1'b0;
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    setCmd(1'b1, 1'b0, 3'd7, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one command, scrambles operands afterwards, and observes the busy window.
  task automatic applyStimulus(input bit sel, input logic [2:0] op, input logic [W-1:0] a, b,
                               output int busyCycles, output int doneCount, output int dbzCount);
    @(negedge clk);
    setCmd(sel, 1'b1, op, a, b);
    @(negedge clk);
    setCmd(sel, 1'b0, 3'($urandom), $urandom, $urandom);
    busyCycles = 0;
    doneCount  = 0;
    dbzCount   = 0;
    while (obsBusy(sel) === 1'b1 && busyCycles <= 200) begin
      busyCycles++;
      doneCount += (obsDone(sel) === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
    doneCount += (obsDone(sel) === 1'b1) ? 1 : 0;
    dbzCount  += (obsDbz(sel) === 1'b1) ? 1 : 0;
    @(negedge clk);
    doneCount += (obsDone(sel) === 1'b1) ? 1 : 0;
    dbzCount  += (obsDbz(sel) === 1'b1) ? 1 : 0;
  endtask

  task automatic test_reset();
    applyReset();
    testsRun++; if (bus.oBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset busy: got %b expected 0", bus.oBusy); end
    testsRun++; if (bus.oHi !== '0) begin testsFailed++; $display("[TB] FAIL reset hi: got %h expected 0", bus.oHi); end
    testsRun++; if (bus.oLo !== '0) begin testsFailed++; $display("[TB] FAIL reset lo: got %h expected 0", bus.oLo); end
    testsRun++; if (bus.oDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset done: got %b expected 0", bus.oDone); end
    testsRun++; if (bus.oDivByZero !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset dbz: got %b expected 0", bus.oDivByZero); end
  endtask

  task automatic test_spec_vectors();
    int bc, dc, zc;
    applyStimulus(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, bc, dc, zc);
    testsRun++; if (bc !== 33) begin testsFailed++; $display("[TB] FAIL mult busy: got %0d expected 33", bc); end
    testsRun++; if (bus.oHi !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL mult hi: got %h expected FFFFFFFF", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'hFFFF_FFEB) begin testsFailed++; $display("[TB] FAIL mult lo: got %h expected FFFFFFEB", bus.oLo); end
    testsRun++; if (dc !== 1) begin testsFailed++; $display("[TB] FAIL mult done: got %0d pulses expected 1", dc); end
    applyStimulus(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, zc);
    testsRun++; if (bus.oHi !== 32'hFFFF_FFFE) begin testsFailed++; $display("[TB] FAIL multu hi: got %h expected FFFFFFFE", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'h0000_0001) begin testsFailed++; $display("[TB] FAIL multu lo: got %h expected 00000001", bus.oLo); end
    applyStimulus(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc, zc);
    testsRun++; if (bc !== 33) begin testsFailed++; $display("[TB] FAIL div busy: got %0d expected 33", bc); end
    testsRun++; if (bus.oLo !== 32'hFFFF_FFFD) begin testsFailed++; $display("[TB] FAIL div lo: got %h expected FFFFFFFD", bus.oLo); end
    testsRun++; if (bus.oHi !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL div hi: got %h expected FFFFFFFF", bus.oHi); end
    applyStimulus(1'b0, 3'd3, 32'd100, 32'd7, bc, dc, zc);
    testsRun++; if (bc !== 33) begin testsFailed++; $display("[TB] FAIL divu busy: got %0d expected 33", bc); end
    testsRun++; if (bus.oLo !== 32'h0000_000E) begin testsFailed++; $display("[TB] FAIL divu lo: got %h expected 0000000E", bus.oLo); end
    testsRun++; if (bus.oHi !== 32'h0000_0002) begin testsFailed++; $display("[TB] FAIL divu hi: got %h expected 00000002", bus.oHi); end
  endtask

  task automatic test_mulstep4();
    int bc, dc, zc;
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, zc);
    testsRun++; if (bc !== 9) begin testsFailed++; $display("[TB] FAIL step4 busy: got %0d expected 9", bc); end
    testsRun++; if (bus4.oHi !== 32'hFFFF_FFFE) begin testsFailed++; $display("[TB] FAIL step4 hi: got %h expected FFFFFFFE", bus4.oHi); end
    testsRun++; if (bus4.oLo !== 32'h0000_0001) begin testsFailed++; $display("[TB] FAIL step4 lo: got %h expected 00000001", bus4.oLo); end
    testsRun++; if (dc !== 1) begin testsFailed++; $display("[TB] FAIL step4 done: got %0d pulses expected 1", dc); end
  endtask

  task automatic test_div_corner();
    int bc, dc, zc;
    applyStimulus(1'b0, 3'd4, 32'hA5A5_0001, '0, bc, dc, zc);
    applyStimulus(1'b0, 3'd5, 32'h5A5A_0002, '0, bc, dc, zc);
    applyStimulus(1'b0, 3'd2, 32'd5, 32'd0, bc, dc, zc);
    testsRun++; if (bc !== 0) begin testsFailed++; $display("[TB] FAIL dbz busy: got %0d cycles expected 0", bc); end
    testsRun++; if (zc !== 1) begin testsFailed++; $display("[TB] FAIL dbz flag: got %0d pulses expected 1", zc); end
    testsRun++; if (dc !== 0) begin testsFailed++; $display("[TB] FAIL dbz done: got %0d pulses expected 0", dc); end
    testsRun++; if (bus.oHi !== 32'hA5A5_0001) begin testsFailed++; $display("[TB] FAIL dbz hi: got %h expected A5A50001", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'h5A5A_0002) begin testsFailed++; $display("[TB] FAIL dbz lo: got %h expected 5A5A0002", bus.oLo); end
    applyStimulus(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, zc);
    testsRun++; if (bus.oLo !== 32'h8000_0000) begin testsFailed++; $display("[TB] FAIL minneg lo: got %h expected 80000000", bus.oLo); end
    testsRun++; if (bus.oHi !== 32'h0) begin testsFailed++; $display("[TB] FAIL minneg hi: got %h expected 0", bus.oHi); end
    testsRun++; if (zc !== 0) begin testsFailed++; $display("[TB] FAIL minneg flag: got %0d pulses expected 0", zc); end
  endtask

  task automatic test_back_to_back();
    bit sawBusy = 1'b0;
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd4, 32'h1234, '0);
    @(negedge clk);
    sawBusy |= (bus.oBusy !== 1'b0);
    setCmd(1'b0, 1'b1, 3'd5, 32'h5678, '0);
    @(negedge clk);
    sawBusy |= (bus.oBusy !== 1'b0);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    @(negedge clk);
    sawBusy |= (bus.oBusy !== 1'b0);
    testsRun++; if (sawBusy) begin testsFailed++; $display("[TB] FAIL mt busy: got raised expected never"); end
    testsRun++; if (bus.oHi !== 32'h1234) begin testsFailed++; $display("[TB] FAIL mthi: got %h expected 00001234", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'h5678) begin testsFailed++; $display("[TB] FAIL mtlo: got %h expected 00005678", bus.oLo); end
  endtask

  task automatic test_flush();
    int bc, dc, zc;
    int doneSeen;
    applyStimulus(1'b0, 3'd4, 32'h1111_1111, '0, bc, dc, zc);
    applyStimulus(1'b0, 3'd5, 32'h2222_2222, '0, bc, dc, zc);
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd0, 32'h0001_2345, 32'h0000_0777);
    @(negedge clk);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    repeat (9) @(negedge clk);
    bus.iFlush = 1'b1;
    @(negedge clk);
    bus.iFlush = 1'b0;
    testsRun++; if (bus.oBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushmul busy: got %b expected 0", bus.oBusy); end
    doneSeen = (bus.oDone === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      doneSeen += (bus.oDone === 1'b1) ? 1 : 0;
    end
    testsRun++; if (doneSeen !== 0) begin testsFailed++; $display("[TB] FAIL flushmul done: got %0d pulses expected 0", doneSeen); end
    testsRun++; if (bus.oHi !== 32'h1111_1111) begin testsFailed++; $display("[TB] FAIL flushmul hi: got %h expected 11111111", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'h2222_2222) begin testsFailed++; $display("[TB] FAIL flushmul lo: got %h expected 22222222", bus.oLo); end

    // Flush landing exactly on the correction cycle.
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd3, 32'd1000, 32'd3);
    @(negedge clk);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    repeat (32) @(negedge clk);
    testsRun++; if (bus.oBusy !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushfix pre busy: got %b expected 1", bus.oBusy); end
    bus.iFlush = 1'b1;
    @(negedge clk);
    bus.iFlush = 1'b0;
    testsRun++; if (bus.oBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushfix busy: got %b expected 0", bus.oBusy); end
    testsRun++; if (bus.oDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushfix done: got %b expected 0", bus.oDone); end
    testsRun++; if (bus.oLo !== 32'h2222_2222) begin testsFailed++; $display("[TB] FAIL flushfix lo: got %h expected 22222222", bus.oLo); end

    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, '0);
    bus.iFlush = 1'b1;
    @(negedge clk);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    bus.iFlush = 1'b0;
    testsRun++; if (bus.oLo !== 32'h2222_2222) begin testsFailed++; $display("[TB] FAIL flushmt lo: got %h expected 22222222", bus.oLo); end

    applyStimulus(1'b0, 3'd1, 32'd6, 32'd7, bc, dc, zc);
    testsRun++; if (bus.oLo !== 32'd42) begin testsFailed++; $display("[TB] FAIL postflush lo: got %h expected 0000002A", bus.oLo); end
  endtask

  task automatic test_ignore_busy();
    int n = 0;
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd1, 32'd3, 32'd5);
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd4, 32'hBAD0_BAD0, '0);
    repeat (5) @(negedge clk);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    while (bus.oBusy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    testsRun++; if (bus.oBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignore timeout: got busy %b expected 0", bus.oBusy); end
    testsRun++; if (bus.oHi !== 32'h0) begin testsFailed++; $display("[TB] FAIL ignore hi: got %h expected 0", bus.oHi); end
    testsRun++; if (bus.oLo !== 32'd15) begin testsFailed++; $display("[TB] FAIL ignore lo: got %h expected 0000000F", bus.oLo); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    setCmd(1'b0, 1'b1, 3'd2, 32'd1000, 32'd7);
    @(negedge clk);
    setCmd(1'b0, 1'b0, 3'd7, '0, '0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    testsRun++; if (bus.oBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset busy: got %b expected 0", bus.oBusy); end
    testsRun++; if (bus.oHi !== '0) begin testsFailed++; $display("[TB] FAIL midreset hi: got %h expected 0", bus.oHi); end
    testsRun++; if (bus.oLo !== '0) begin testsFailed++; $display("[TB] FAIL midreset lo: got %h expected 0", bus.oLo); end
    testsRun++; if (bus.oDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset done: got %b expected 0", bus.oDone); end
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [W-1:0] expHi [2];
    logic [W-1:0] expLo [2];
    logic [W-1:0] a, b, hiM, loM;
    logic [2:0]   op;
    bit           sel;
    int           lat, dbz, bc, dc, zc;
    applyReset();
    expHi[0] = '0; expLo[0] = '0; expHi[1] = '0; expLo[1] = '0;
    for (int i = 0; i < 80; i++) begin
      sel = (i % 4 == 3);
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      hiM = expHi[sel];
      loM = expLo[sel];
      refModel(op, a, b, sel ? 4 : 1, hiM, loM, lat, dbz);
      expHi[sel] = hiM;
      expLo[sel] = loM;
      applyStimulus(sel, op, a, b, bc, dc, zc);
      testsRun++; if (bc !== lat) begin testsFailed++; $display("[TB] FAIL rand%0d op%0d busy: got %0d expected %0d", i, op, bc, lat); end
      testsRun++; if (dc !== ((lat > 0) ? 1 : 0)) begin testsFailed++; $display("[TB] FAIL rand%0d op%0d done: got %0d expected %0d", i, op, dc, (lat > 0) ? 1 : 0); end
      testsRun++; if (zc !== dbz) begin testsFailed++; $display("[TB] FAIL rand%0d op%0d dbz: got %0d expected %0d", i, op, zc, dbz); end
      testsRun++; if (obsHi(sel) !== hiM) begin testsFailed++; $display("[TB] FAIL rand%0d op%0d hi: a=%h b=%h got %h expected %h", i, op, a, b, obsHi(sel), hiM); end
      testsRun++; if (obsLo(sel) !== loM) begin testsFailed++; $display("[TB] FAIL rand%0d op%0d lo: a=%h b=%h got %h expected %h", i, op, a, b, obsLo(sel), loM); end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_mulstep4();
    test_div_corner();
    test_back_to_back();
    test_flush();
    test_ignore_busy();
    test_reset_mid_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
